// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_port_arbiter_pkg: shared widths and FSM states for the MEM-stage data-memory arbiter.
package dmem_port_arbiter_pkg;
   localparam int DMEM_ADDR_W    = 8;
   localparam int DMEM_DATA_W    = 32;
   localparam int CONFLICT_CNT_W = 16;
   typedef enum logic {IDLE, SECOND} arb_state_e;
endpackage

// File: rtl/dmem_port_arbiter_sat_counter.sv
// sat_counter: saturating event counter with synchronous clear and asynchronous active-low reset.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc_i,
   input  logic             clear_i,
   output logic [CNT_W-1:0] cnt_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clear_i ? '0 : (inc_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk or negedge reset)
      if (!reset) cnt_q <= '0;
      else cnt_q <= cnt_d;
   assign cnt_o = cnt_q;
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: serialises dual-lane loads/stores onto a single-port data memory,
// lane 0 first, buffering lane 0 read data so both lanes write back together.
module dmem_port_arbiter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = DMEM_ADDR_W,
   parameter int DATA_W = DMEM_DATA_W,
   parameter int CNT_W  = CONFLICT_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_i,
   input  logic              req1_i,
   input  logic              we0_i,
   input  logic              we1_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [DATA_W-1:0] wdata0_i,
   input  logic [DATA_W-1:0] wdata1_i,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_we_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic [DATA_W-1:0] rdata0_o,
   output logic [DATA_W-1:0] rdata1_o,
   output logic              stall_o,
   output logic              wb_en_o,
   output logic [CNT_W-1:0]  conflict_cnt_o
);
   arb_state_e        state_q, state_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              sec, conflict, lane1;
   // Reset gates conflict and write so nothing is issued while the pipeline is being reset.
   always_comb begin
      sec         = state_q == SECOND;
      conflict    = reset && !sec && req0_i && req1_i;
      lane1       = sec || (!req0_i && req1_i);
      mem_addr_o  = lane1 ? addr1_i : addr0_i;
      mem_wdata_o = lane1 ? wdata1_i : wdata0_i;
      mem_we_o    = reset && (lane1 ? (req1_i && we1_i) : (req0_i && we0_i));
      rdata0_o    = sec ? hold_q : mem_rdata_i;
      rdata1_o    = mem_rdata_i;
      stall_o     = conflict;
      wb_en_o     = !conflict;
      state_d     = conflict ? SECOND : IDLE;
      hold_d      = conflict ? mem_rdata_i : hold_q;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q <= IDLE;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc_i   (conflict),
      .clear_i (1'b0),
      .cnt_o   (conflict_cnt_o)
   );
endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-lane arbiter for the single-port data memory in the dual-issue pipeline's MEM stage. Each lane presents its load/store request from its EX/MEM register. Single requests pass straight through. When both lanes access memory in the same cycle, the arbiter serialises them over two cycles, lane 0 (older) first. During the first cycle it stalls the pipeline and holds the MEM/WB registers, and it buffers lane 0 read data so that both lanes write back together.

## Interface
Parameters:
- ADDR_W, 8, data-memory word-address width
- DATA_W, 32, data width
- CNT_W, 16, conflict-counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req0_i / req1_i  in  1  lane 0/1 memory access valid (MemRead | MemWrite)
- we0_i / we1_i  in  1  lane 0/1 is a store
- addr0_i / addr1_i  in  ADDR_W  lane 0/1 word address
- wdata0_i / wdata1_i  in  DATA_W  lane 0/1 store data
- mem_addr_o  out  ADDR_W  address to data memory
- mem_we_o  out  1  memory write enable
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, combinational from mem_addr_o
- rdata0_o / rdata1_o  out  DATA_W  read data to lane 0/1 MEM/WB inputs
- stall_o  out  1  freeze PC, IF/ID, ID/EX and EX/MEM of both lanes
- wb_en_o  out  1  MEM/WB load enable for both lanes
- conflict_cnt_o  out  CNT_W  saturating count of conflict cycles

## Operation
- The FSM has two states: IDLE and SECOND.
- **IDLE, no requests:**
  - mem_we_o=0.
  - mem_addr_o and mem_wdata_o are driven from lane 0.
  - stall_o=0, wb_en_o=1.
- **IDLE, exactly one request:**
  - The requesting lane drives the memory port.
  - That lane's rdata output = mem_rdata_i. The other lane's rdata output also = mem_rdata_i; it is don't-care.
  - stall_o=0, wb_en_o=1. The FSM stays in IDLE.
- **IDLE, both requests (conflict):**
  - Lane 0 drives the memory port.
  - stall_o=1, wb_en_o=0.
  - hold_q <= mem_rdata_i.
  - conflict_cnt increments, saturating at all-ones.
  - Next state: SECOND.
- **SECOND:**
  - Lane 1 drives the memory port.
  - rdata0_o=hold_q, rdata1_o=mem_rdata_i.
  - stall_o=0, wb_en_o=1.
  - Next state: IDLE.
  - Inputs are not re-sampled; EX/MEM was frozen, so they are unchanged.
- **Ordering:** lane 0 always accesses memory before lane 1. This gives the following results:
  - Store0 then load1 to the same address: load1 returns the new data.
  - Load0 then store1 to the same address: load0 returns the old data.
  - Two stores to the same address: lane 1's value persists.
- mem_we_o equals the active lane's we AND req. No write is ever issued without req.

## Timing
- All outputs except the hold, state and counter registers are combinational from the inputs and the state.
- **Latency:** zero extra cycles for zero or one request; exactly one extra cycle per conflict.
- **Reset** (asynchronous, when reset is low):
  - state=IDLE, hold_q=0, conflict_cnt_o=0.
  - mem_we_o forced 0, stall_o=0.
  - wb_en_o=1, rdata outputs = mem_rdata_i.
- **Reset asserted in SECOND:** the lane 1 access is dropped (no write). The pipeline registers reset simultaneously.
- **Back-to-back conflicts:** the sequence is IDLE→SECOND→IDLE→SECOND, one stall every other cycle. Worst-case throughput is one bundle per 2 cycles.
- Upstream must treat stall_o as a register hold, not a flush.

## Structure
- Shared package holds:
  - the state enum (IDLE, SECOND)
  - default ADDR_W, DATA_W and CNT_W constants, shared with the memory and pipeline registers
- The saturating counter is a natural small sub-module, sat_counter (parameter CNT_W, inputs inc/clear). Everything else stays flat.

## Test plan
- **Single load:** req0=1, we0=0, addr0=0x05, mem[5]=0xDEADBEEF → same cycle mem_addr_o=0x05, rdata0_o=0xDEADBEEF, stall_o=0, wb_en_o=1.
- **Conflict load/load:** req0/req1 with addr 0x01/0x02, mem=0x11/0x22 →
  - cycle 1: stall_o=1, wb_en_o=0, mem_addr_o=0x01.
  - cycle 2: mem_addr_o=0x02, rdata0_o=0x11, rdata1_o=0x22, wb_en_o=1.
  - conflict_cnt_o=1.
- **Store0/load1 to address 0x07, wdata0=0xCAFE0000:**
  - cycle 1: mem_we_o=1.
  - cycle 2: rdata1_o=0xCAFE0000.
- **Back-to-back conflicts ×3:** stall_o pattern 1,0,1,0,1,0; conflict_cnt_o=3.
- **Counter saturation:** with CNT_W=2 and 5 conflicts, conflict_cnt_o stays at 3.
- **Reset in SECOND** during a store1 conflict: no write to the lane 1 address; state returns to IDLE; conflict_cnt_o=0.
